sdp_brdma_rsp_arb: RTL and testbench
====================================

// Module: sdp_brdma_rsp_arb
// PURPOSE
//  Merges the MCIF and CVIF read-response streams of the SDP B-side DMA into one egress stream toward the BRDMA unpacker.
//  Round-robin arbitration, per-layer beat accounting, layer-done pulse.
//  The registered egress stage is a pipe/skid pair: all outputs are flop-driven, and no in_ready depends combinationally on out_ready.
// PARAMETERS
//  PD_W   514  response payload width (512 data + 2 mask)
//  CNT_W  22   width of the per-layer beat counter and cfg_beat_total
// PORTS
//  nvdla_core_clk      in   1      clock
//  nvdla_core_rstn     in   1      reset, asynchronous, active-low
//  mc_rsp_valid        in   1      MCIF response valid
//  mc_rsp_ready        out  1      MCIF response ready
//  mc_rsp_pd           in   PD_W   MCIF response payload
//  cv_rsp_valid        in   1      CVIF response valid
//  cv_rsp_ready        out  1      CVIF response ready
//  cv_rsp_pd           in   PD_W   CVIF response payload
//  out_valid           out  1      merged response valid
//  out_ready           in   1      merged response ready
//  out_pd              out  PD_W   merged response payload
//  op_load             in   1      one-cycle pulse: start layer
//  cfg_beat_total      in   CNT_W  beats expected this layer; sampled on op_load
//  busy                out  1      high from the cycle after op_load until layer_done
//  layer_done          out  1      one-cycle pulse: layer complete
// BEHAVIOUR
//  Reset values
//   - out_valid=0, busy=0, layer_done=0, rr_last=CV (so MCIF wins the first tie).
//   - Counter=0, state=IDLE. Payload flops are not reset.
//  FSM
//   - IDLE -> RUN on op_load with cfg_beat_total!=0.
//   - IDLE -> DRAIN on op_load with cfg_beat_total==0.
//   - RUN -> DRAIN in the cycle the accepted-beat count reaches cfg_beat_total.
//   - DRAIN -> IDLE once pipe and skid are both empty. layer_done pulses on that transition.
//   - op_load outside IDLE is ignored.
//  Input ready
//   - mc/cv_rsp_ready is asserted only in RUN, and only when pipe_ready_bc=(pipe_ready | !pipe_valid).
//   - At most one source is ready per cycle: the grant.
//  Arbitration
//   - Both sources valid: grant the source != rr_last.
//   - One source valid: grant that source.
//   - rr_last updates only on an accepted beat (valid & ready).
//   - Grant is a function of the current valid inputs. A stalled requester therefore keeps its priority.
//  Counting
//   - The counter increments by 1 per accepted beat.
//   - The last beat (count==total-1) is accepted, then the state goes to DRAIN. Further beats are refused (ready=0).
//  Egress
//   - Identical to the team's p2 pipe: pipe register plus one skid entry.
//   - Latency: 1 cycle from input accept to out_valid when unstalled.
//   - Full throughput of 1 beat/clk.
//   - The skid catches when pipe_valid & pipe_ready & !out_ready.
//   - out_pd is held stable while out_valid & !out_ready.
//  Reset mid-layer
//   - Everything returns to reset values and in-flight beats are dropped.
//   - No layer_done pulse is issued.
//  Simultaneous events
//   - op_load in the same cycle as layer_done (DRAIN->IDLE) is ignored. The controller waits for busy=0.
// CONFIGURATION
//  SDP_BRDMA_RSP_ARB_PERF_EN
//   - Defined: adds outputs perf_mc_beats[31:0], perf_cv_beats[31:0] and perf_stall[31:0].
//   - perf_stall counts cycles with out_valid & !out_ready.
//   - All three are saturating counters. They clear on op_load and on reset.
//   - Undefined: the ports and counters are absent, and functional behaviour is identical.
// STRUCTURE
//  Shared package sdp_brdma_pkg
//   - PD_W
//   - State enum {IDLE, RUN, DRAIN}
//   - Source enum {SRC_MC, SRC_CV}
//  One sub-module: sdp_brdma_rsp_skid, the pipe+skid egress stage, parameterised on PD_W.
//  Arbiter, FSM and counter stay in the top level.
// TESTING
//  1. total=4, MC only, out_ready=1
//     -> 4 beats out in order, each 1 cycle after accept.
//     -> layer_done pulses once, busy falls the same cycle.
//  2. total=6, MC and CV both always valid, out_ready=1
//     -> grants alternate MC,CV,MC,CV,MC,CV.
//     -> payload order matches grant order.
//  3. total=8, out_ready toggling 1/0 every cycle
//     -> no beat lost or duplicated, and out_pd stable while stalled.
//     -> skid used; mc_rsp_ready deasserts one cycle after the stall.
//  4. total=0 op_load
//     -> no input ever readied; layer_done 2 cycles after op_load.
//  5. total=3 with a 4th MC beat pending
//     -> 4th beat held with ready=0.
//     -> after the next op_load (total=1) it is accepted first.
//  6. Reset asserted after 2 of 5 beats
//     -> out_valid=0 and busy=0 immediately (async).
//     -> no layer_done; a following layer with total=2 completes normally.

Source files
------------

// File: rtl/sdp_brdma_pkg.sv
// ---------------------------------------------------------------------------
// sdp_brdma_pkg
//   Shared definitions for the SDP B-side DMA read-response path.
//   PD_W   : response payload width (512 data bits + 2 mask bits)
//   CNT_W  : width of the per-layer beat counter / cfg_beat_total
//   state_e: layer controller states
//   src_e  : response source identifiers used by the round-robin arbiter
// ---------------------------------------------------------------------------
package sdp_brdma_pkg;

  localparam int PD_W  = 514;
  localparam int CNT_W = 22;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    SRC_MC = 1'b0,
    SRC_CV = 1'b1
  } src_e;

endpackage

// File: rtl/sdp_brdma_rsp_arb_if.sv
// ---------------------------------------------------------------------------
// sdp_brdma_rsp_arb_if
//   Bundles the three valid/ready streams of the response arbiter:
//     mc_rsp_*  : MCIF read-response stream (into the arbiter)
//     cv_rsp_*  : CVIF read-response stream (into the arbiter)
//     out_*     : merged stream toward the BRDMA unpacker
//   modport slave  : the arbiter side (consumes mc/cv, produces out)
//   modport master : the environment side (produces mc/cv, consumes out)
// ---------------------------------------------------------------------------
interface sdp_brdma_rsp_arb_if
  import sdp_brdma_pkg::*;
#(
  parameter int PD_W = sdp_brdma_pkg::PD_W
);

  logic            mc_rsp_valid;
  logic            mc_rsp_ready;
  logic [PD_W-1:0] mc_rsp_pd;
  logic            cv_rsp_valid;
  logic            cv_rsp_ready;
  logic [PD_W-1:0] cv_rsp_pd;
  logic            out_valid;
  logic            out_ready;
  logic [PD_W-1:0] out_pd;

  modport slave (
    input  mc_rsp_valid, mc_rsp_pd,
    input  cv_rsp_valid, cv_rsp_pd,
    input  out_ready,
    output mc_rsp_ready, cv_rsp_ready,
    output out_valid, out_pd
  );

  modport master (
    output mc_rsp_valid, mc_rsp_pd,
    output cv_rsp_valid, cv_rsp_pd,
    output out_ready,
    input  mc_rsp_ready, cv_rsp_ready,
    input  out_valid, out_pd
  );

endinterface

// File: rtl/sdp_brdma_rsp_skid.sv
// ---------------------------------------------------------------------------
// sdp_brdma_rsp_skid
//   Registered egress stage: a pipe register that drives the outputs plus a
//   single skid entry. in_ready_o is derived from flops only, so it never
//   depends combinationally on out_ready_i. 1-cycle latency, 1 beat/clk.
// Ports
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   in_valid_i / in_ready_o / in_pd_i     : upstream beat
//   out_valid_o / out_ready_i / out_pd_o  : downstream beat (flop-driven)
//   idle_o                                : pipe and skid both empty
// ---------------------------------------------------------------------------
module sdp_brdma_rsp_skid
  import sdp_brdma_pkg::*;
#(
  parameter int PD_W = sdp_brdma_pkg::PD_W
) (
  input  logic            nvdla_core_clk,
  input  logic            nvdla_core_rstn,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [PD_W-1:0] in_pd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PD_W-1:0] out_pd_o,
  output logic            idle_o
);

  logic            pipe_valid_q, pipe_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [PD_W-1:0] pipe_pd_q;
  logic [PD_W-1:0] skid_pd_q;
  logic            pipe_ready;
  logic            in_acc;
  logic            out_stall;
  logic            load_pipe_in;
  logic            load_pipe_skid;
  logic            load_skid;

  // The pipe can always hand its beat on while the skid is free.
  assign pipe_ready = !skid_valid_q;
  assign in_ready_o = pipe_ready | !pipe_valid_q;
  assign in_acc     = in_valid_i & in_ready_o;
  assign out_stall  = pipe_valid_q & !out_ready_i;

  always_comb begin
    pipe_valid_d   = pipe_valid_q;
    skid_valid_d   = skid_valid_q;
    load_pipe_in   = 1'b0;
    load_pipe_skid = 1'b0;
    load_skid      = 1'b0;
    if (out_stall) begin
      // Pipe is held; a beat accepted now has to land in the skid.
      if (in_acc) begin
        skid_valid_d = 1'b1;
        load_skid    = 1'b1;
      end
    end else if (skid_valid_q) begin
      // Skid refills the pipe first; no accept is possible this cycle.
      pipe_valid_d   = 1'b1;
      skid_valid_d   = 1'b0;
      load_pipe_skid = 1'b1;
    end else begin
      pipe_valid_d = in_acc;
      load_pipe_in = in_acc;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      pipe_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload flops carry no reset; their valid bits qualify them.
  always_ff @(posedge nvdla_core_clk) begin
    if (load_skid) begin
      skid_pd_q <= in_pd_i;
    end
    if (load_pipe_in) begin
      pipe_pd_q <= in_pd_i;
    end else if (load_pipe_skid) begin
      pipe_pd_q <= skid_pd_q;
    end
  end

  assign out_valid_o = pipe_valid_q;
  assign out_pd_o    = pipe_pd_q;
  assign idle_o      = !pipe_valid_q & !skid_valid_q;

endmodule

// File: rtl/sdp_brdma_rsp_arb.sv
// ---------------------------------------------------------------------------
// sdp_brdma_rsp_arb
//   Merges the MCIF and CVIF read-response streams of the SDP B-side DMA into
//   one egress stream toward the BRDMA unpacker. Round-robin arbitration,
//   per-layer beat accounting and a layer-done pulse. Egress goes through the
//   sdp_brdma_rsp_skid pipe/skid stage, so every output is flop-driven.
// Ports
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   rsp_if (slave)   : mc_rsp_*, cv_rsp_* in; out_* merged stream out
//   op_load          : 1-cycle pulse, start a layer (IDLE only)
//   cfg_beat_total   : beats expected this layer, sampled on op_load
//   busy             : high from the cycle after op_load until layer_done
//   layer_done       : 1-cycle pulse when the layer has fully drained
// Optional feature macro: SDP_BRDMA_RSP_ARB_PERF_EN
//   Adds saturating perf_mc_beats / perf_cv_beats / perf_stall counters,
//   cleared on op_load and on reset.
// ---------------------------------------------------------------------------
module sdp_brdma_rsp_arb
  import sdp_brdma_pkg::*;
#(
  parameter int PD_W  = sdp_brdma_pkg::PD_W,
  parameter int CNT_W = sdp_brdma_pkg::CNT_W
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  sdp_brdma_rsp_arb_if.slave   rsp_if,
  input  logic                 op_load,
  input  logic [CNT_W-1:0]     cfg_beat_total,
  output logic                 busy,
  output logic                 layer_done
`ifdef SDP_BRDMA_RSP_ARB_PERF_EN
  ,
  output logic [31:0]          perf_mc_beats,
  output logic [31:0]          perf_cv_beats,
  output logic [31:0]          perf_stall
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] total_q, total_d;
  src_e             rr_last_q, rr_last_d;
  logic             busy_q, busy_d;
  logic             layer_done_q, layer_done_d;

  logic             pipe_ready_bc;
  logic             pipe_idle;
  logic             load_ok;
  logic             grant_mc, grant_cv;
  logic             in_open;
  logic             mc_acc, cv_acc, acc;
  logic             last_beat;
  logic [PD_W-1:0]  acc_pd;

  // A load arriving while layer_done is still showing belongs to the old
  // layer's handshake window and is dropped.
  assign load_ok = op_load & (state_q == IDLE) & !layer_done_q;

  // Grant looks only at current valids, so a stalled requester keeps its turn.
  assign grant_cv = rsp_if.cv_rsp_valid & (!rsp_if.mc_rsp_valid | (rr_last_q == SRC_MC));
  assign grant_mc = rsp_if.mc_rsp_valid & !grant_cv;

  assign in_open             = (state_q == RUN) & pipe_ready_bc;
  assign rsp_if.mc_rsp_ready = in_open & grant_mc;
  assign rsp_if.cv_rsp_ready = in_open & grant_cv;

  assign mc_acc    = rsp_if.mc_rsp_valid & rsp_if.mc_rsp_ready;
  assign cv_acc    = rsp_if.cv_rsp_valid & rsp_if.cv_rsp_ready;
  assign acc       = mc_acc | cv_acc;
  assign acc_pd    = mc_acc ? rsp_if.mc_rsp_pd : rsp_if.cv_rsp_pd;
  assign last_beat = acc & (cnt_q == (total_q - CNT_W'(1)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    total_d      = total_q;
    busy_d       = busy_q;
    layer_done_d = 1'b0;
    rr_last_d    = rr_last_q;
    if (mc_acc) begin
      rr_last_d = SRC_MC;
    end else if (cv_acc) begin
      rr_last_d = SRC_CV;
    end
    case (state_q)
      IDLE: begin
        if (load_ok) begin
          total_d = cfg_beat_total;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (cfg_beat_total != '0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        if (acc) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (last_beat) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_idle) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          layer_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      total_q      <= '0;
      rr_last_q    <= SRC_CV;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      total_q      <= total_d;
      rr_last_q    <= rr_last_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign busy       = busy_q;
  assign layer_done = layer_done_q;

  sdp_brdma_rsp_skid #(
    .PD_W (PD_W)
  ) u_skid (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .in_valid_i      (acc),
    .in_ready_o      (pipe_ready_bc),
    .in_pd_i         (acc_pd),
    .out_valid_o     (rsp_if.out_valid),
    .out_ready_i     (rsp_if.out_ready),
    .out_pd_o        (rsp_if.out_pd),
    .idle_o          (pipe_idle)
  );

`ifdef SDP_BRDMA_RSP_ARB_PERF_EN
  logic [2:0] perf_inc;

  assign perf_inc[0] = mc_acc;
  assign perf_inc[1] = cv_acc;
  assign perf_inc[2] = rsp_if.out_valid & !rsp_if.out_ready;

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [31:0] cnt_q;
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
        cnt_q <= '0;
      end else if (op_load) begin
        cnt_q <= '0;
      end else if (perf_inc[gi] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign perf_mc_beats = g_perf[0].cnt_q;
  assign perf_cv_beats = g_perf[1].cnt_q;
  assign perf_stall    = g_perf[2].cnt_q;
`endif

endmodule

// File: tb/tb_sdp_brdma_rsp_arb.sv
module tb_sdp_brdma_rsp_arb;
  import sdp_brdma_pkg::*;

  localparam logic [7:0] SM = 8'h4D;
  localparam logic [7:0] SC = 8'h43;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             op_load = 1'b0;
  logic [CNT_W-1:0] cfg = '0;
  logic             busy;
  logic             layer_done;
`ifdef SDP_BRDMA_RSP_ARB_PERF_EN
  logic [31:0]      perf_mc_beats, perf_cv_beats, perf_stall;
`endif

  always #5 clk = ~clk;

  sdp_brdma_rsp_arb_if rif ();

  sdp_brdma_rsp_arb dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .rsp_if          (rif),
    .op_load         (op_load),
    .cfg_beat_total  (cfg),
    .busy            (busy),
    .layer_done      (layer_done)
`ifdef SDP_BRDMA_RSP_ARB_PERF_EN
    ,
    .perf_mc_beats   (perf_mc_beats),
    .perf_cv_beats   (perf_cv_beats),
    .perf_stall      (perf_stall)
`endif
  );

  typedef struct {
    logic        mc_v, cv_v, o_rdy;
    logic        e_mc_rdy, e_cv_rdy, e_ov;
    logic [7:0]  e_src;
    logic [15:0] e_seq;
    logic        e_busy, e_ld;
  } vec_t;

  vec_t tbl [17];

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int n_ld = 0;
  int n_catch = 0;
  logic [15:0] mc_seq, cv_seq;
  logic [PD_W-1:0] sb [$];
  logic [PD_W-1:0] prev_pd;
  logic prev_stall, prev_catch, mc_acc, cv_acc;

  function automatic logic [PD_W-1:0] mk_pd(input logic [7:0] src, input logic [15:0] seq);
    logic [PD_W-1:0] p;
    p = '0;
    p[15:0] = seq;
    p[23:16] = src;
    p[400 +: 16] = ~seq;
    p[PD_W-1 -: 2] = seq[1:0];
    return p;
  endfunction

  function automatic vec_t mkv(input logic mv, cv, ordy, emr, ecr, eov,
                               input logic [7:0] src, input logic [15:0] seq,
                               input logic eb, eld);
    vec_t v;
    v.mc_v = mv; v.cv_v = cv; v.o_rdy = ordy;
    v.e_mc_rdy = emr; v.e_cv_rdy = ecr; v.e_ov = eov;
    v.e_src = src; v.e_seq = seq; v.e_busy = eb; v.e_ld = eld;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_pd(input string nm, input logic [PD_W-1:0] act, input logic [PD_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act[23:0], exp[23:0], $time);
    end
  endtask

  // Sample at the falling edge: scoreboard order, hold-while-stalled, skid-full.
  task automatic at_neg();
    @(negedge clk);
    mc_acc = rif.mc_rsp_valid & rif.mc_rsp_ready;
    cv_acc = rif.cv_rsp_valid & rif.cv_rsp_ready;
    if (prev_catch) chk1("skid_full_no_ready", rif.mc_rsp_ready | rif.cv_rsp_ready, 1'b0);
    if (prev_stall) begin
      chk1("hold_valid", rif.out_valid, 1'b1);
      chk_pd("hold_pd", rif.out_pd, prev_pd);
    end
    if (rif.out_valid & rif.out_ready) begin
      chk1("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) chk_pd("order", rif.out_pd, sb.pop_front());
      n_out++;
    end
    prev_stall = rif.out_valid & !rif.out_ready;
    prev_pd = rif.out_pd;
    prev_catch = prev_stall & (mc_acc | cv_acc);
    if (prev_catch) n_catch++;
    if (mc_acc) sb.push_back(rif.mc_rsp_pd);
    if (cv_acc) sb.push_back(rif.cv_rsp_pd);
    if (layer_done) n_ld++;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
    if (mc_acc) begin mc_seq++; rif.mc_rsp_pd = mk_pd(SM, mc_seq); end
    if (cv_acc) begin cv_seq++; rif.cv_rsp_pd = mk_pd(SC, cv_seq); end
    mc_acc = 1'b0;
    cv_acc = 1'b0;
  endtask

  task automatic clear_bench();
    sb.delete();
    mc_seq = '0; cv_seq = '0;
    rif.mc_rsp_pd = mk_pd(SM, 16'd0);
    rif.cv_rsp_pd = mk_pd(SC, 16'd0);
    rif.mc_rsp_valid = 1'b0; rif.cv_rsp_valid = 1'b0; rif.out_ready = 1'b1;
    prev_stall = 1'b0; prev_catch = 1'b0; mc_acc = 1'b0; cv_acc = 1'b0;
    op_load = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_bench();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic load(input logic [CNT_W-1:0] total);
    cfg = total;
    op_load = 1'b1;
    at_neg();
    to_next();
    op_load = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bound);
    logic done;
    done = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      at_neg();
      if (layer_done) done = 1'b1;
      to_next();
    end
    chk1(nm, done, 1'b1);
  endtask

  task automatic run_tbl(input int lo, input int hi, input logic [CNT_W-1:0] total);
    do_reset();
    rif.mc_rsp_valid = tbl[lo].mc_v;
    rif.cv_rsp_valid = tbl[lo].cv_v;
    rif.out_ready = tbl[lo].o_rdy;
    load(total);
    for (int i = lo; i <= hi; i++) begin
      rif.mc_rsp_valid = tbl[i].mc_v;
      rif.cv_rsp_valid = tbl[i].cv_v;
      rif.out_ready = tbl[i].o_rdy;
      at_neg();
      chk1($sformatf("row%0d_mc_ready", i), rif.mc_rsp_ready, tbl[i].e_mc_rdy);
      chk1($sformatf("row%0d_cv_ready", i), rif.cv_rsp_ready, tbl[i].e_cv_rdy);
      chk1($sformatf("row%0d_out_valid", i), rif.out_valid, tbl[i].e_ov);
      chk1($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
      chk1($sformatf("row%0d_layer_done", i), layer_done, tbl[i].e_ld);
      if (tbl[i].e_ov) chk_pd($sformatf("row%0d_out_pd", i), rif.out_pd, mk_pd(tbl[i].e_src, tbl[i].e_seq));
      to_next();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int out0, ld0;
    // mc_v cv_v ordy | mc_rdy cv_rdy ov src seq | busy ld
    // Case 1: total=4, MC only
    tbl[0]  = mkv(1, 0, 1, 1, 0, 0, SM, 16'd0, 1, 0);
    tbl[1]  = mkv(1, 0, 1, 1, 0, 1, SM, 16'd0, 1, 0);
    tbl[2]  = mkv(1, 0, 1, 1, 0, 1, SM, 16'd1, 1, 0);
    tbl[3]  = mkv(1, 0, 1, 1, 0, 1, SM, 16'd2, 1, 0);
    tbl[4]  = mkv(1, 0, 1, 0, 0, 1, SM, 16'd3, 1, 0);
    tbl[5]  = mkv(1, 0, 1, 0, 0, 0, SM, 16'd0, 1, 0);
    tbl[6]  = mkv(1, 0, 1, 0, 0, 0, SM, 16'd0, 0, 1);
    tbl[7]  = mkv(0, 0, 1, 0, 0, 0, SM, 16'd0, 0, 0);
    // Case 2: total=6, both always valid -> MC,CV,MC,CV,MC,CV
    tbl[8]  = mkv(1, 1, 1, 1, 0, 0, SM, 16'd0, 1, 0);
    tbl[9]  = mkv(1, 1, 1, 0, 1, 1, SM, 16'd0, 1, 0);
    tbl[10] = mkv(1, 1, 1, 1, 0, 1, SC, 16'd0, 1, 0);
    tbl[11] = mkv(1, 1, 1, 0, 1, 1, SM, 16'd1, 1, 0);
    tbl[12] = mkv(1, 1, 1, 1, 0, 1, SC, 16'd1, 1, 0);
    tbl[13] = mkv(1, 1, 1, 0, 1, 1, SM, 16'd2, 1, 0);
    tbl[14] = mkv(1, 1, 1, 0, 0, 1, SC, 16'd2, 1, 0);
    tbl[15] = mkv(0, 0, 1, 0, 0, 0, SM, 16'd0, 1, 0);
    tbl[16] = mkv(0, 0, 1, 0, 0, 0, SM, 16'd0, 0, 1);

    clear_bench();
    #3;
    chk1("reset_out_valid", rif.out_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_layer_done", layer_done, 1'b0);

    run_tbl(0, 7, 22'd4);
    run_tbl(8, 16, 22'd6);

    // Case 3: total=8, out_ready toggling every cycle
    do_reset();
    out0 = n_out; ld0 = n_ld; n_catch = 0;
    rif.mc_rsp_valid = 1'b1;
    load(22'd8);
    for (int k = 0; k < 60 && n_ld == ld0; k++) begin
      at_neg();
      to_next();
      rif.out_ready = ~rif.out_ready;
    end
    chkn("t3_beats_out", n_out - out0, 8);
    chkn("t3_beats_in", int'(mc_seq), 8);
    chkn("t3_layer_done", n_ld - ld0, 1);
    chkn("t3_sb_empty", sb.size(), 0);
    chk1("t3_skid_used", n_catch > 0, 1'b1);
    rif.out_ready = 1'b1;

    // Case 4: total=0, plus op_load coinciding with layer_done
    do_reset();
    rif.mc_rsp_valid = 1'b1; rif.cv_rsp_valid = 1'b1;
    load(22'd0);
    at_neg();
    chk1("t4_c1_mc_ready", rif.mc_rsp_ready, 1'b0);
    chk1("t4_c1_cv_ready", rif.cv_rsp_ready, 1'b0);
    chk1("t4_c1_busy", busy, 1'b1);
    chk1("t4_c1_layer_done", layer_done, 1'b0);
    to_next();
    cfg = 22'd5; op_load = 1'b1;
    at_neg();
    chk1("t4_c2_layer_done", layer_done, 1'b1);
    chk1("t4_c2_busy", busy, 1'b0);
    chk1("t4_c2_mc_ready", rif.mc_rsp_ready, 1'b0);
    to_next();
    op_load = 1'b0;
    at_neg();
    chk1("t4_load_ignored_busy", busy, 1'b0);
    chk1("t4_load_ignored_ready", rif.mc_rsp_ready | rif.cv_rsp_ready, 1'b0);
    to_next();

    // Case 5: total=3 with a 4th MC beat pending
    do_reset();
    rif.mc_rsp_valid = 1'b1;
    load(22'd3);
    wait_done("t5_done_timeout", 30);
    chkn("t5_accepted", int'(mc_seq), 3);
    at_neg();
    chk1("t5_held_ready", rif.mc_rsp_ready, 1'b0);
    chk1("t5_idle_busy", busy, 1'b0);
    to_next();
    load(22'd1);
    at_neg();
    chk1("t5_4th_ready", rif.mc_rsp_ready, 1'b1);
    to_next();
    rif.mc_rsp_valid = 1'b0;
    at_neg();
    chk1("t5_4th_out_valid", rif.out_valid, 1'b1);
    chk_pd("t5_4th_out_pd", rif.out_pd, mk_pd(SM, 16'd3));
    to_next();
    wait_done("t5b_done_timeout", 20);

    // Case 6: reset after 2 of 5 beats
    do_reset();
    rif.mc_rsp_valid = 1'b1;
    load(22'd5);
    at_neg(); to_next();
    at_neg(); to_next();
    chk1("t6_pre_out_valid", rif.out_valid, 1'b1);
    chk1("t6_pre_busy", busy, 1'b1);
    rstn = 1'b0;
    #1;
    chk1("t6_rst_out_valid", rif.out_valid, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_mc_ready", rif.mc_rsp_ready, 1'b0);
    clear_bench();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("t6_rst_no_done", layer_done, 1'b0);
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      chk1("t6_post_no_done", layer_done, 1'b0);
      to_next();
    end
    out0 = n_out; ld0 = n_ld;
    rif.mc_rsp_valid = 1'b1;
    load(22'd2);
    wait_done("t6_done_timeout", 20);
    chkn("t6_beats_out", n_out - out0, 2);
    chkn("t6_layer_done", n_ld - ld0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
